// File: rtl/wrr_arb_pkg.sv
// Shared helpers for the weighted round-robin arbiters: index width and the
// wrapped first-one search used for pointer-relative priority.
package wrr_arb_pkg;

    localparam int unsigned MaxIn   = 64;
    localparam int unsigned MaxIdxW = 6;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Scans start+1, start+2, ... (mod n) with start itself checked last.
    // Returns start when nothing in req[n-1:0] is set.
    function automatic int unsigned wrap_first_one(input logic [MaxIn-1:0] req,
                                                   input int unsigned       n,
                                                   input int unsigned       start);
        int unsigned hit;
        int unsigned idx;
        hit = start;
        for (int k = MaxIn; k > 0; k--) begin
            if (unsigned'(k) <= n) begin
                idx = (start + unsigned'(k)) % n;
                if (req[idx[MaxIdxW-1:0]]) hit = idx;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/wrr_arb_tree_out_reg.sv
// One-entry valid/ready pipeline register; full throughput when the consumer
// keeps out_ready_i high.
module arb_out_reg
    import wrr_arb_pkg::*;
#(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             vld_q, vld_d;
    logic [Width-1:0] data_q, data_d;

    assign in_ready_o  = !vld_q || out_ready_i;
    assign out_valid_o = vld_q;
    assign out_data_o  = data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            vld_d  = 1'b1;
            data_d = in_data_i;
        end else if (out_ready_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter: the owner keeps max(weight,1) consecutive
// grants, then ownership moves to the next requester after the pointer.
module wrr_arb_tree
    import wrr_arb_pkg::*;
#(
    parameter int unsigned NumIn       = 8,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WeightWidth = 4,
    parameter int unsigned LockIn      = 1,
    parameter int unsigned OutReg      = 0,
    parameter int unsigned IdxWidth    = idx_width(NumIn)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NumIn*WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]             req_i,
    output logic [NumIn-1:0]             gnt_o,
    input  logic [NumIn*DataWidth-1:0]   data_i,
    output logic                         req_o,
    input  logic                         gnt_i,
    output logic [DataWidth-1:0]         data_o,
    output logic [IdxWidth-1:0]          idx_o
);

    logic [NumIn-1:0][WeightWidth-1:0] weight;
    logic [NumIn-1:0][DataWidth-1:0]   data;
    logic [MaxIn-1:0]                  req_ext;

    logic [IdxWidth-1:0]    ptr_q, ptr_d, lidx_q, lidx_d, sel;
    logic [WeightWidth-1:0] cnt_q, cnt_d, w_sel;
    logic                   lock_q, lock_d, lock_ok;
    logic                   int_valid, int_ready, hs;

    assign weight = weight_i;
    assign data   = data_i;

    always_comb begin
        req_ext             = '0;
        req_ext[NumIn-1:0]  = req_i;
    end

    // Outputs are forced idle while reset is held, even with OutReg=0.
    assign int_valid = (|req_i) & ~rst_i;
    assign hs        = int_valid && int_ready && !flush_i;
    assign lock_ok   = (LockIn != 0) && lock_q && req_i[lidx_q];
    assign w_sel     = weight[sel];

    always_comb begin
        sel = IdxWidth'(wrap_first_one(req_ext, NumIn, int'(ptr_q)));
        if (lock_ok) begin
            sel = lidx_q;
        end else if (req_i[ptr_q] && cnt_q != '0) begin
            sel = ptr_q;
        end
    end

    always_comb begin
        gnt_o      = '0;
        gnt_o[sel] = hs;
    end

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        lock_d = lock_q;
        lidx_d = lidx_q;
        if (flush_i) begin
            ptr_d  = '0;
            cnt_d  = '0;
            lock_d = 1'b0;
            lidx_d = '0;
        end else begin
            if (hs) begin
                if (sel == ptr_q && cnt_q != '0) begin
                    cnt_d = cnt_q - WeightWidth'(1);
                end else begin
                    ptr_d = sel;
                    cnt_d = (w_sel == '0) ? '0 : w_sel - WeightWidth'(1);
                end
            end
            lock_d = (LockIn != 0) && int_valid && !int_ready;
            if (lock_d) lidx_d = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end

    generate
        if (OutReg != 0) begin : g_oreg
            logic [DataWidth+IdxWidth-1:0] oq;
            arb_out_reg #(
                .Width(DataWidth + IdxWidth)
            ) u_out_reg (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .flush_i    (flush_i),
                .in_valid_i (int_valid),
                .in_ready_o (int_ready),
                .in_data_i  ({data[sel], sel}),
                .out_valid_o(req_o),
                .out_ready_i(gnt_i),
                .out_data_o (oq)
            );
            assign data_o = oq[DataWidth+IdxWidth-1:IdxWidth];
            assign idx_o  = oq[IdxWidth-1:0];
        end else begin : g_comb
            assign int_ready = gnt_i;
            assign req_o     = int_valid;
            assign data_o    = int_valid ? data[sel] : '0;
            assign idx_o     = int_valid ? sel : '0;
        end
    endgenerate

    // A locked requester must keep requesting until it is granted.
    lock_hold_a: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        ((LockIn != 0) && lock_q) |-> req_i[lidx_q]);

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Directed bench: three arbiter configurations driven from one clock/reset.
module tb_wrr_arb_tree;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // A: NumIn=4, LockIn=1, OutReg=0
    logic         flush_a, gnt_a, reqo_a;
    logic [3:0]   req_a, gnto_a;
    logic [15:0]  wt_a;
    logic [127:0] dat_a;
    logic [31:0]  dato_a;
    logic [1:0]   idxo_a;
    // B: NumIn=4, OutReg=1
    logic         flush_b, gnt_b, reqo_b;
    logic [3:0]   req_b, gnto_b;
    logic [15:0]  wt_b;
    logic [127:0] dat_b;
    logic [31:0]  dato_b;
    logic [1:0]   idxo_b;
    // C: NumIn=5, OutReg=0
    logic         flush_c, gnt_c, reqo_c;
    logic [4:0]   req_c, gnto_c;
    logic [19:0]  wt_c;
    logic [159:0] dat_c;
    logic [31:0]  dato_c;
    logic [2:0]   idxo_c;

    wrr_arb_tree #(.NumIn(4), .DataWidth(32), .WeightWidth(4), .LockIn(1), .OutReg(0)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .weight_i(wt_a), .req_i(req_a),
        .gnt_o(gnto_a), .data_i(dat_a), .req_o(reqo_a), .gnt_i(gnt_a), .data_o(dato_a), .idx_o(idxo_a));
    wrr_arb_tree #(.NumIn(4), .DataWidth(32), .WeightWidth(4), .LockIn(1), .OutReg(1)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .weight_i(wt_b), .req_i(req_b),
        .gnt_o(gnto_b), .data_i(dat_b), .req_o(reqo_b), .gnt_i(gnt_b), .data_o(dato_b), .idx_o(idxo_b));
    wrr_arb_tree #(.NumIn(5), .DataWidth(32), .WeightWidth(4), .LockIn(1), .OutReg(0)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_c), .weight_i(wt_c), .req_i(req_c),
        .gnt_o(gnto_c), .data_i(dat_c), .req_o(reqo_c), .gnt_i(gnt_c), .data_o(dato_c), .idx_o(idxo_c));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int e1[5]  = '{1, 2, 3, 0, 1};
    int e2[14] = '{1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    int e3[3]  = '{4, 0, 4};

    initial begin
        rst = 1'b1;
        flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        req_a = 4'hF;  gnt_a = 1'b1; wt_a = 16'h1111;
        dat_a = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        req_b = '0; gnt_b = 1'b0; wt_b = 16'h1111; dat_b = '0;
        req_c = '0; gnt_c = 1'b0; wt_c = 20'h11111; dat_c = '0;
        #2;
        chk("rst_req_a", reqo_a, 0);
        chk("rst_gnt_a", gnto_a, 0);
        chk("rst_idx_a", idxo_a, 0);
        chk("rst_req_b", reqo_b, 0);
        chk("rst_data_b", dato_b, 0);
        chk("rst_gnt_c", gnto_c, 0);
        step(); step();
        rst = 1'b0;
        #1;

        // plain round robin, weights 1
        for (int i = 0; i < 5; i++) begin
            chk("a_rr_idx", idxo_a, e1[i]);
            chk("a_rr_gnt", gnto_a, 64'(1) << e1[i]);
            chk("a_rr_data", dato_a, 32'hD0 + e1[i]);
            step();
        end

        // weights w0=3 w1=1 w2=2 w3=0, flush takes priority over the handshake
        flush_a = 1'b1;
        wt_a = {4'd0, 4'd2, 4'd1, 4'd3};
        #1;
        chk("a_flush_gnt", gnto_a, 0);
        step();
        flush_a = 1'b0;
        #1;
        for (int i = 0; i < 14; i++) begin
            chk("a_wrr_idx", idxo_a, e2[i]);
            chk("a_wrr_gnt", gnto_a, 64'(1) << e2[i]);
            step();
        end

        // lock-in: park ptr at 2, stall on 1, a later req[3] must not steal
        flush_a = 1'b1; wt_a = 16'h1111;
        #1;
        step();
        flush_a = 1'b0; req_a = 4'b0100; gnt_a = 1'b1;
        #1;
        chk("a_lk_pre_idx", idxo_a, 2);
        chk("a_lk_pre_gnt", gnto_a, 4'b0100);
        step();
        req_a = 4'b0010; gnt_a = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("a_lk_stall_idx", idxo_a, 1);
            chk("a_lk_stall_gnt", gnto_a, 0);
            chk("a_lk_stall_req", reqo_a, 1);
            step();
        end
        req_a = 4'b1010;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("a_lk_hold_idx", idxo_a, 1);
            chk("a_lk_hold_gnt", gnto_a, 0);
            step();
        end
        gnt_a = 1'b1;
        #1;
        chk("a_lk_rel_idx", idxo_a, 1);
        chk("a_lk_rel_gnt", gnto_a, 4'b0010);
        step();
        chk("a_lk_next_idx", idxo_a, 3);
        chk("a_lk_next_gnt", gnto_a, 4'b1000);
        req_a = '0;

        // registered output: single requester 2 streaming
        req_b = 4'b0100; gnt_b = 1'b1; dat_b[64 +: 32] = 32'hB0;
        #1;
        chk("b_first_req", reqo_b, 0);
        chk("b_first_gnt", gnto_b, 4'b0100);
        step();
        for (int i = 1; i < 5; i++) begin
            dat_b[64 +: 32] = 32'hB0 + i;
            #1;
            chk("b_strm_req", reqo_b, 1);
            chk("b_strm_data", dato_b, 32'hB0 + i - 1);
            chk("b_strm_idx", idxo_b, 2);
            chk("b_strm_gnt", gnto_b, 4'b0100);
            step();
        end
        gnt_b = 1'b0; dat_b[64 +: 32] = 32'hC0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("b_stall_gnt", gnto_b, 0);
            chk("b_stall_req", reqo_b, 1);
            chk("b_stall_data", dato_b, 32'hB4);
            step();
        end

        // flush against owner 2 with cnt 2 and a full output buffer
        flush_b = 1'b1;
        #1;
        step();
        flush_b = 1'b0; wt_b = {4'd1, 4'd3, 4'd1, 4'd1}; gnt_b = 1'b1;
        #1;
        chk("b_own_gnt", gnto_b, 4'b0100);
        step();
        flush_b = 1'b1;
        #1;
        chk("b_flush_gnt", gnto_b, 0);
        step();
        flush_b = 1'b0; req_b = 4'b0110;
        #1;
        chk("b_postfl_req", reqo_b, 0);
        chk("b_postfl_gnt", gnto_b, 4'b0010);
        step();
        chk("b_postfl_idx", idxo_b, 1);
        chk("b_postfl_vld", reqo_b, 1);

        // NumIn=5 wrap, then asynchronous reset mid-stream
        req_c = 5'b10001; gnt_c = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("c_wrap_idx", idxo_c, e3[i]);
            chk("c_wrap_gnt", gnto_c, 64'(1) << e3[i]);
            step();
        end
        rst = 1'b1;
        #1;
        chk("c_rst_req", reqo_c, 0);
        chk("c_rst_gnt", gnto_c, 0);
        chk("c_rst_req_b", reqo_b, 0);
        step();
        rst = 1'b0;
        #1;
        chk("c_after_idx", idxo_c, 4);
        chk("c_after_gnt", gnto_c, 5'b10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
